// File: rtl/mastermind_round_ctrl.sv
// Round sequencer for the mastermind datapath: turns key presses into per-peg load strobes,
// fires a compare pulse after each full guess, then counts guesses and flags win or loss.
module mastermind_round_ctrl #(
  parameter int NUM_PEGS    = 4,
  parameter int MAX_GUESSES = 8,
  parameter int CNT_W       = 3,
  parameter int SLOT_W      = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1,
  parameter int GC_W        = $clog2(MAX_GUESSES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                new_game,
  input  logic [CNT_W-1:0]    red_in,
  output logic [NUM_PEGS-1:0] load_code,
  output logic [NUM_PEGS-1:0] load_guess,
  output logic                compare,
  output logic [SLOT_W-1:0]   slot,
  output logic [GC_W-1:0]     guess_count,
  output logic                win,
  output logic                lose,
  output logic [1:0]          phase
);

  typedef enum logic [2:0] {
    S_CODE, S_GUESS, S_COMPARE, S_EVAL, S_DONE
  } state_t;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_PEGS - 1);
  localparam logic [GC_W-1:0]   MAX_GC    = GC_W'(MAX_GUESSES);
  localparam logic [CNT_W-1:0]  ALL_RED   = CNT_W'(NUM_PEGS);

  state_t state, state_next;
  logic   load_q, ng_q;
  logic   press, restart, last_slot, is_win;

  logic [NUM_PEGS-1:0] load_code_d, load_guess_d;
  logic                compare_d, win_d, lose_d;
  logic [SLOT_W-1:0]   slot_d;
  logic [GC_W-1:0]     guess_count_d, count_inc;
  logic [1:0]          phase_d;

  assign press     = load & ~load_q;
  assign restart   = new_game & ~ng_q;
  assign last_slot = (slot == LAST_SLOT);
  assign is_win    = (red_in == ALL_RED);
  assign count_inc = (guess_count == MAX_GC) ? MAX_GC : guess_count + GC_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous because the board logic expects it that way.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_CODE;
      load_q      <= 1'b1;  // a key held through reset must not register as a press
      ng_q        <= 1'b1;
      load_code   <= '0;
      load_guess  <= '0;
      compare     <= 1'b0;
      slot        <= '0;
      guess_count <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      phase       <= 2'd0;
    end else begin
      state       <= state_next;
      load_q      <= load;
      ng_q        <= new_game;
      load_code   <= load_code_d;
      load_guess  <= load_guess_d;
      compare     <= compare_d;
      slot        <= slot_d;
      guess_count <= guess_count_d;
      win         <= win_d;
      lose        <= lose_d;
      phase       <= phase_d;
    end
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = S_CODE;
    end else begin
      case (state)
        S_CODE:    if (press && last_slot) state_next = S_GUESS;
        S_GUESS:   if (press && last_slot) state_next = S_COMPARE;
        S_COMPARE: state_next = S_EVAL;
        S_EVAL:    state_next = (is_win || count_inc == MAX_GC) ? S_DONE : S_GUESS;
        default:   state_next = state;
      endcase
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    load_code_d   = '0;
    load_guess_d  = '0;
    compare_d     = 1'b0;
    slot_d        = slot;
    guess_count_d = guess_count;
    win_d         = win;
    lose_d        = lose;
    if (restart) begin
      slot_d        = '0;
      guess_count_d = '0;
      win_d         = 1'b0;
      lose_d        = 1'b0;
    end else begin
      case (state)
        S_CODE: if (press) begin
          load_code_d = NUM_PEGS'(1) << slot;
          slot_d      = last_slot ? '0 : slot + SLOT_W'(1);
        end
        S_GUESS: if (press) begin
          load_guess_d = NUM_PEGS'(1) << slot;
          slot_d       = last_slot ? '0 : slot + SLOT_W'(1);
        end
        S_COMPARE: compare_d = 1'b1;
        S_EVAL: begin
          guess_count_d = count_inc;
          win_d         = is_win;
          lose_d        = !is_win && (count_inc == MAX_GC);
          slot_d        = '0;
        end
        default: ;
      endcase
    end

    case (state_next)
      S_CODE:             phase_d = 2'd0;
      S_GUESS:            phase_d = 2'd1;
      S_COMPARE, S_EVAL:  phase_d = 2'd2;
      default:            phase_d = 2'd3;
    endcase
  end

endmodule
